// File: rtl/counter_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_monitor_if
//  Description : Observed counter stream (dut_rst, cnt, limit, skip) and the
//                decoded monitor results, grouped as one bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_monitor_if #(
    parameter int CNT_W  = 10,
    parameter int STEP_W = 16
);
    // Counter side (observed)
    logic                     dut_rst;
    logic signed [CNT_W-1:0]  cnt;
    logic                     limit;
    logic                     skip;

    // Monitor side (decoded results)
    logic                     mode;
    logic                     mode_vld;
    logic                     at_limit;
    logic [STEP_W-1:0]        step_cnt;
    logic [7:0]               skip_cnt;
    logic                     err;
    logic [2:0]               err_code;

    // Whoever produces the counter stream and consumes the results
    modport master (
        output dut_rst, cnt, limit, skip,
        input  mode, mode_vld, at_limit, step_cnt, skip_cnt, err, err_code
    );

    // The monitor itself
    modport slave (
        input  dut_rst, cnt, limit, skip,
        output mode, mode_vld, at_limit, step_cnt, skip_cnt, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/counter_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : counter_monitor
//  Description : Passive checker for the lab up/down counter. Resynchronises
//                on the counter's reset value, decodes direction, counts
//                normal and double steps, and latches the first violation.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_monitor #(
    parameter int CNT_W  = 10,
    parameter int STEP_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    counter_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAIL  = 2'd2
    } state_t;

    // Deltas and thresholds are evaluated one bit wider than cnt so that
    // cnt - prev can never overflow.
    localparam int DW = CNT_W + 1;
    localparam logic signed [DW-1:0] C_START  = DW'(-50);
    localparam logic signed [DW-1:0] C_P5     = DW'(5);
    localparam logic signed [DW-1:0] C_P10    = DW'(10);
    localparam logic signed [DW-1:0] C_M9     = DW'(-9);
    localparam logic signed [DW-1:0] C_M18    = DW'(-18);
    localparam logic signed [DW-1:0] C_DBL_UP = DW'(-16);
    localparam logic signed [DW-1:0] C_DBL_DN = DW'(-2);
    localparam logic signed [DW-1:0] C_TOP    = DW'(230);
    localparam logic signed [DW-1:0] C_BOT    = DW'(-221);

    localparam logic [2:0] C_ERR_START = 3'd1;
    localparam logic [2:0] C_ERR_DELTA = 3'd2;
    localparam logic [2:0] C_ERR_TRANS = 3'd3;
    localparam logic [2:0] C_ERR_FLAG  = 3'd4;

    state_t                  state_q,    state_d;
    logic signed [CNT_W-1:0] prev_q,     prev_d;
    logic                    mode_q,     mode_d;
    logic                    mode_vld_q, mode_vld_d;
    logic                    at_limit_q, at_limit_d;
    logic [STEP_W-1:0]       step_cnt_q, step_cnt_d;
    logic [7:0]              skip_cnt_q, skip_cnt_d;
    logic                    err_q,      err_d;
    logic [2:0]              err_code_q, err_code_d;

    logic signed [DW-1:0] cnt_x;
    logic signed [DW-1:0] prev_x;
    logic signed [DW-1:0] delta;
    logic is_p5, is_p10, is_m9, is_m18, is_hold, is_double;
    logic delta_ok, trans_ok, flag_ok;

    assign cnt_x  = {bus.cnt[CNT_W-1], bus.cnt};
    assign prev_x = {prev_q[CNT_W-1], prev_q};
    assign delta  = cnt_x - prev_x;

    assign is_p5     = (delta == C_P5);
    assign is_p10    = (delta == C_P10);
    assign is_m9     = (delta == C_M9);
    assign is_m18    = (delta == C_M18);
    assign is_hold   = (delta == '0);
    assign is_double = is_p10 | is_m18;
    assign delta_ok  = is_p5 | is_p10 | is_m9 | is_m18 | is_hold;

    // Double steps happen only at the two fixed skip points; holds only
    // beyond the end thresholds; single steps everywhere else.
    assign trans_ok  = (is_p5   && (prev_x != C_DBL_UP) && (prev_x <= C_TOP))
                     | (is_p10  && (prev_x == C_DBL_UP))
                     | (is_m9   && (prev_x != C_DBL_DN) && (prev_x >= C_BOT))
                     | (is_m18  && (prev_x == C_DBL_DN))
                     | (is_hold && ((prev_x > C_TOP) || (prev_x < C_BOT)));

    assign flag_ok   = (bus.limit == !is_hold) && (bus.skip == !is_double);

    // Next-state and next-output decode; FAIL falls through the defaults so
    // everything freezes there.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        mode_d     = mode_q;
        mode_vld_d = mode_vld_q;
        at_limit_d = at_limit_q;
        step_cnt_d = step_cnt_q;
        skip_cnt_d = skip_cnt_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_SYNC: begin
                if (!bus.dut_rst) begin
                    if (cnt_x == C_START) begin
                        prev_d  = bus.cnt;
                        state_d = ST_TRACK;
                    end else begin
                        err_code_d = C_ERR_START;
                        err_d      = 1'b1;
                        state_d    = ST_FAIL;
                    end
                end
            end

            ST_TRACK: begin
                if (bus.dut_rst) begin
                    state_d = ST_SYNC;
                end else if (!delta_ok) begin
                    err_code_d = C_ERR_DELTA;
                    err_d      = 1'b1;
                    state_d    = ST_FAIL;
                end else if (!trans_ok) begin
                    err_code_d = C_ERR_TRANS;
                    err_d      = 1'b1;
                    state_d    = ST_FAIL;
                end else if (!flag_ok) begin
                    err_code_d = C_ERR_FLAG;
                    err_d      = 1'b1;
                    state_d    = ST_FAIL;
                end else begin
                    prev_d     = bus.cnt;
                    at_limit_d = is_hold;
                    if (!is_hold) begin
                        mode_d     = ~delta[DW-1];
                        mode_vld_d = 1'b1;
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                    if (is_double && (skip_cnt_q != 8'hFF)) begin
                        skip_cnt_d = skip_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
            end
        endcase
    end

    // State and result registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            prev_q     <= '0;
            mode_q     <= 1'b0;
            mode_vld_q <= 1'b0;
            at_limit_q <= 1'b0;
            step_cnt_q <= '0;
            skip_cnt_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            mode_q     <= mode_d;
            mode_vld_q <= mode_vld_d;
            at_limit_q <= at_limit_d;
            step_cnt_q <= step_cnt_d;
            skip_cnt_q <= skip_cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.mode_vld = mode_vld_q;
    assign bus.at_limit = at_limit_q;
    assign bus.step_cnt = step_cnt_q;
    assign bus.skip_cnt = skip_cnt_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_monitor
//  Description : Self-checking bench for counter_monitor: directed scenarios
//                plus a randomized stream compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_counter_monitor;

    localparam int CNT_W  = 10;
    localparam int STEP_W = 6;   // narrow so the step counter wraps in a short run

    localparam int M_SYNC  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAIL  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_st, m_prev, m_steps, m_skips, m_code;
    bit m_mode, m_vld, m_at;

    counter_monitor_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus ();

    counter_monitor #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic bit legal_move(int p, int d);
        case (d)
            5:       return (p != -16) && (p <= 230);
            10:      return (p == -16);
            -9:      return (p != -2) && (p >= -221);
            -18:     return (p == -2);
            0:       return (p > 230) || (p < -221);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = M_SYNC; m_prev = 0; m_steps = 0; m_skips = 0; m_code = 0;
        m_mode = 0; m_vld = 0; m_at = 0;
    endtask

    task automatic model_step(bit dr, int c, bit l, bit s);
        int d;
        if (m_st == M_SYNC) begin
            if (!dr) begin
                if (c == -50) begin m_prev = -50; m_st = M_TRACK; end
                else begin m_code = 1; m_st = M_FAIL; end
            end
        end else if (m_st == M_TRACK) begin
            d = c - m_prev;
            if (dr) m_st = M_SYNC;
            else if (!(d inside {5, 10, -9, -18, 0})) begin m_code = 2; m_st = M_FAIL; end
            else if (!legal_move(m_prev, d)) begin m_code = 3; m_st = M_FAIL; end
            else if ((l != (d != 0)) || (s != !(d == 10 || d == -18))) begin
                m_code = 4; m_st = M_FAIL;
            end else begin
                m_prev = c;
                m_at   = (d == 0);
                if (d > 0) m_mode = 1;
                if (d < 0) m_mode = 0;
                if (d != 0) begin m_vld = 1; m_steps++; end
                if ((d == 10 || d == -18) && m_skips < 255) m_skips++;
            end
        end
    endtask

    // -------------------------------------------------------------- drivers
    task automatic drive(bit dr, int c, bit l, bit s);
        bus.dut_rst = dr;
        bus.cnt     = CNT_W'(c);
        bus.limit   = l;
        bus.skip    = s;
        @(posedge clk);
        model_step(dr, c, l, s);
        #1;
    endtask

    task automatic step(int d);
        drive(1'b0, m_prev + d, d != 0, !(d == 10 || d == -18));
    endtask

    task automatic rst_assert();
        rst = 1'b1;
        #2;
        model_reset();
    endtask

    task automatic rst_release();
        rst = 1'b0;
    endtask

    task automatic start();
        rst_assert();
        rst_release();
        drive(1'b1, -50, 1'b0, 1'b0);
        drive(1'b0, -50, 1'b1, 1'b1);
    endtask

    function automatic int pick_delta(int p, bit up);
        int q[$];
        int pref[$];
        foreach (q[i]) q.delete(i);
        if (legal_move(p, 5))   q.push_back(5);
        if (legal_move(p, 10))  q.push_back(10);
        if (legal_move(p, -9))  q.push_back(-9);
        if (legal_move(p, -18)) q.push_back(-18);
        if (legal_move(p, 0))   q.push_back(0);
        foreach (q[i]) if ((q[i] > 0) == up && q[i] != 0) pref.push_back(q[i]);
        if (pref.size() > 0 && $urandom_range(0, 3) != 0)
            return pref[$urandom_range(0, pref.size() - 1)];
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        bus.dut_rst = 1'b0; bus.cnt = '0; bus.limit = 1'b0; bus.skip = 1'b0;
        #1;
        rst_assert();
        n_vec++;
        if ({bus.mode, bus.mode_vld, bus.at_limit, bus.step_cnt, bus.skip_cnt,
             bus.err, bus.err_code} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got mode=%b vld=%b at=%b step=%0d skip=%0d err=%b code=%0d, expected all 0",
                     bus.mode, bus.mode_vld, bus.at_limit, bus.step_cnt, bus.skip_cnt, bus.err, bus.err_code);
        end
        rst_release();
    endtask

    task automatic test_bad_start();
        rst_assert();
        rst_release();
        drive(1'b0, -45, 1'b1, 1'b1);
        n_vec++;
        if (bus.err !== 1'b1) begin
            n_err++; $display("FAIL bad_start_err: got %b, expected 1", bus.err);
        end
        n_vec++;
        if (bus.err_code !== 3'd1) begin
            n_err++; $display("FAIL bad_start_code: got %0d, expected 1", bus.err_code);
        end
    endtask

    task automatic test_up_run();
        start();
        for (int i = 0; i < 57; i++) step(5);
        step(0);
        n_vec++;
        if ({bus.mode, bus.step_cnt, bus.at_limit, bus.err} !== {1'b1, STEP_W'(57), 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL up_run: got mode=%b step=%0d at=%b err=%b, expected mode=1 step=57 at=1 err=0",
                     bus.mode, bus.step_cnt, bus.at_limit, bus.err);
        end
    endtask

    task automatic test_double_step();
        start();
        for (int i = 0; i < 14; i++) step(5);
        for (int i = 0; i < 4; i++) step(-9);
        step(10);
        n_vec++;
        if ({bus.skip_cnt, bus.mode, bus.step_cnt, bus.err} !== {8'd1, 1'b1, STEP_W'(19), 1'b0}) begin
            n_err++;
            $display("FAIL double_step: got skip=%0d mode=%b step=%0d err=%b, expected skip=1 mode=1 step=19 err=0",
                     bus.skip_cnt, bus.mode, bus.step_cnt, bus.err);
        end
        // Loop -6 -> -16 -> -6 repeatedly to drive skip_cnt into saturation.
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 5; i++) step(-9);
            for (int i = 0; i < 7; i++) step(5);
            step(10);
        end
        n_vec++;
        if ({bus.skip_cnt, bus.step_cnt, bus.err} !== {8'd255, STEP_W'(19 + 260 * 13), 1'b0}) begin
            n_err++;
            $display("FAIL skip_saturate: got skip=%0d step=%0d err=%b, expected skip=255 step=%0d err=0",
                     bus.skip_cnt, bus.step_cnt, bus.err, (19 + 260 * 13) % (1 << STEP_W));
        end
    endtask

    task automatic test_illegal();
        start();
        for (int i = 0; i < 30; i++) step(5);
        drive(1'b0, 110, 1'b1, 1'b0);
        n_vec++;
        if ({bus.err, bus.err_code} !== {1'b1, 3'd3}) begin
            n_err++; $display("FAIL illegal_transition: got err=%b code=%0d, expected err=1 code=3", bus.err, bus.err_code);
        end
        start();
        drive(1'b0, -43, 1'b1, 1'b1);
        n_vec++;
        if ({bus.err, bus.err_code} !== {1'b1, 3'd2}) begin
            n_err++; $display("FAIL illegal_delta: got err=%b code=%0d, expected err=1 code=2", bus.err, bus.err_code);
        end
    endtask

    task automatic test_flag_mismatch();
        start();
        drive(1'b0, -45, 1'b0, 1'b1);
        n_vec++;
        if ({bus.err, bus.err_code} !== {1'b1, 3'd4}) begin
            n_err++; $display("FAIL flag_mismatch: got err=%b code=%0d, expected err=1 code=4", bus.err, bus.err_code);
        end
        drive(1'b1, -50, 1'b0, 1'b0);
        drive(1'b1, -50, 1'b0, 1'b0);
        drive(1'b0, -50, 1'b1, 1'b1);
        n_vec++;
        if ({bus.err, bus.err_code, bus.step_cnt} !== {1'b1, 3'd4, STEP_W'(0)}) begin
            n_err++; $display("FAIL fail_sticky: got err=%b code=%0d step=%0d, expected err=1 code=4 step=0",
                              bus.err, bus.err_code, bus.step_cnt);
        end
        rst_assert();
        n_vec++;
        if ({bus.err, bus.err_code} !== {1'b0, 3'd0}) begin
            n_err++; $display("FAIL async_clear: got err=%b code=%0d, expected err=0 code=0", bus.err, bus.err_code);
        end
        rst_release();
    endtask

    task automatic test_dut_rst_mid();
        start();
        for (int i = 0; i < 5; i++) step(-9);
        drive(1'b1, 7, 1'b0, 1'b0);     // would be an illegal delta; counter reset wins
        drive(1'b1, -50, 1'b1, 1'b1);
        n_vec++;
        if ({bus.err, bus.step_cnt, bus.mode_vld} !== {1'b0, STEP_W'(5), 1'b1}) begin
            n_err++; $display("FAIL dut_rst_hold: got err=%b step=%0d vld=%b, expected err=0 step=5 vld=1",
                              bus.err, bus.step_cnt, bus.mode_vld);
        end
        drive(1'b0, -50, 1'b0, 1'b0);   // stale flags are not checked on resync
        step(-9);
        n_vec++;
        if ({bus.err, bus.step_cnt, bus.mode} !== {1'b0, STEP_W'(6), 1'b0}) begin
            n_err++; $display("FAIL dut_rst_mid: got err=%b step=%0d mode=%b, expected err=0 step=6 mode=0",
                              bus.err, bus.step_cnt, bus.mode);
        end
    endtask

    task automatic test_random();
        bit up = 1'b1;
        int r, d;
        logic [20:0] act, exp_v;
        start();
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if ($urandom_range(0, 15) == 0) up = ~up;
            if (r < 8 || (m_st == M_FAIL && r < 100)) begin
                rst_assert();
                act = {bus.mode, bus.mode_vld, bus.at_limit, bus.step_cnt, bus.skip_cnt, bus.err, bus.err_code};
                n_vec++;
                if (act !== '0) begin
                    n_err++; $display("FAIL random_rst[%0d]: got %h, expected 0", i, act);
                end
                rst_release();
                continue;
            end
            if (m_st == M_FAIL || r < 30)
                drive(1'($urandom_range(0, 1) == 0 && r < 30), int'($urandom_range(0, 1023)) - 512,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (m_st == M_SYNC)
                drive(1'b0, (r < 60) ? int'($urandom_range(0, 1023)) - 512 : -50,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (r < 36)
                drive(1'b0, m_prev + int'($urandom_range(0, 40)) - 20,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (r < 42) begin
                d = pick_delta(m_prev, up);
                drive(1'b0, m_prev + d, (d != 0) ^ (r < 39), !(d == 10 || d == -18) ^ (r >= 39));
            end else
                step(pick_delta(m_prev, up));
            act   = {bus.mode, bus.mode_vld, bus.at_limit, bus.step_cnt, bus.skip_cnt, bus.err, bus.err_code};
            exp_v = {m_mode, m_vld, m_at, STEP_W'(m_steps), 8'(m_skips), (m_st == M_FAIL), 3'(m_code)};
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL random[%0d]: got {mode,vld,at,step,skip,err,code}=%h, expected %h", i, act, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bad_start();
        test_up_run();
        test_double_step();
        test_illegal();
        test_flag_mismatch();
        test_dut_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
